// File: rtl/elastic_alu_out_stage_pkg.sv
// elastic_alu_out_stage_pkg
// Shared definitions for the elastic PE output stage:
//   - default parameter constants
//   - opcode enumeration and a result-producing predicate
//   - elastic wire bundle (data / valid / stop) at the default data width
// Optional feature macro used by the files importing this package: ELASTIC_DEBUG_EN
package elastic_alu_out_stage_pkg;

    localparam int DEF_DATA_WIDTH           = 32;
    localparam int DEF_ADDRESS_WIDTH        = 32;
    localparam int DEF_OPERATION_BIT_LENGTH = 4;
    localparam int DEF_NEIGHBOR_PE_NUM      = 4;
    localparam int DEF_BUFFER_SIZE_BITS     = 2;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_CONST = 4'd4,
        OP_LOAD  = 4'd5,
        OP_STORE = 4'd6,
        OP_ROUTE = 4'd7
    } opcode_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      valid;
        logic                      stop;
    } elastic_wire_t;

    // STORE and NOP consume operands but never emit a token.
    function automatic logic op_has_result(input opcode_e o);
        return (o != OP_NOP) && (o != OP_STORE);
    endfunction

endpackage

// File: rtl/elastic_fifo.sv
// elastic_fifo
// Elastic buffer of depth 2**ADDR_BITS between the ALU register and the fork.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push, push_data     write one entry (ignored when full)
//   pop                 retire head entry (ignored when empty)
//   head_data           current head entry
//   full, empty         status flags
//   occupancy           entry count, present only with ELASTIC_DEBUG_EN
module elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
`ifdef ELASTIC_DEBUG_EN
    ,
    output logic [ADDR_BITS:0]    occupancy
`endif
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    // One extra pointer bit separates full from empty when the indices match.
    logic [ADDR_BITS:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]) &&
                   (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        // Full blocks a push even when a pop happens in the same cycle.
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        head_data = mem_q[rd_ptr_q[ADDR_BITS-1:0]];
    end

`ifdef ELASTIC_DEBUG_EN
    assign occupancy = wr_ptr_q - rd_ptr_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem_q[gi] <= '0;
            end else if (do_push && (wr_ptr_q[ADDR_BITS-1:0] == ADDR_BITS'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

endmodule

// File: rtl/elastic_alu_out_stage.sv
// elastic_alu_out_stage
// Output stage of an elastic CGRA PE: one-deep ALU register, elastic FIFO and
// an eager fork broadcasting each result once to every enabled neighbour.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   input_data_1/2, valid_input       joined operand pair
//   stop_input                        back-pressure to the join
//   op, const_data                    current context opcode / constant
//   switch_context                    one-cycle pulse after each firing
//   memory_read_address/data          combinational load port
//   memory_write_address/data/write   registered store port
//   available_output                  fork enable mask
//   pe_output_data, valid_output, stop_output   fork outputs
//   DEBUG_data_size                   FIFO occupancy, only with ELASTIC_DEBUG_EN
module elastic_alu_out_stage
    import elastic_alu_out_stage_pkg::*;
#(
    parameter int DATA_WIDTH                     = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH                  = DEF_ADDRESS_WIDTH,
    parameter int OPERATION_BIT_LENGTH           = DEF_OPERATION_BIT_LENGTH,
    parameter int NEIGHBOR_PE_NUM                = DEF_NEIGHBOR_PE_NUM,
    parameter int ELASTIC_BUFFER_SIZE_BIT_LENGTH = DEF_BUFFER_SIZE_BITS
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic [DATA_WIDTH-1:0]                       input_data_1,
    input  logic [DATA_WIDTH-1:0]                       input_data_2,
    input  logic                                        valid_input,
    output logic                                        stop_input,
    input  logic [OPERATION_BIT_LENGTH-1:0]             op,
    input  logic [DATA_WIDTH-1:0]                       const_data,
    output logic                                        switch_context,
    output logic [ADDRESS_WIDTH-1:0]                    memory_read_address,
    input  logic [DATA_WIDTH-1:0]                       memory_read_data,
    output logic [ADDRESS_WIDTH-1:0]                    memory_write_address,
    output logic [DATA_WIDTH-1:0]                       memory_write_data,
    output logic                                        memory_write,
    input  logic [NEIGHBOR_PE_NUM-1:0]                  available_output,
    output logic [NEIGHBOR_PE_NUM-1:0][DATA_WIDTH-1:0]  pe_output_data,
    output logic [NEIGHBOR_PE_NUM-1:0]                  valid_output,
    input  logic [NEIGHBOR_PE_NUM-1:0]                  stop_output
`ifdef ELASTIC_DEBUG_EN
    ,
    output logic [ELASTIC_BUFFER_SIZE_BIT_LENGTH:0]     DEBUG_data_size
`endif
);
    // ALU register and registered side outputs
    logic                     alu_valid_q, alu_valid_d;
    logic [DATA_WIDTH-1:0]    alu_data_q, alu_data_d;
    logic                     switch_context_q, switch_context_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NEIGHBOR_PE_NUM-1:0] done_q, done_d;

    opcode_e               op_dec;
    logic                  fire;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [NEIGHBOR_PE_NUM-1:0] out_ok;

    always_comb begin
        // Opcodes beyond ROUTE decode to NOP.
        op_dec = (op > OPERATION_BIT_LENGTH'(OP_ROUTE)) ? OP_NOP
                                                        : opcode_e'({1'b0, op[2:0]});

        fifo_push = alu_valid_q & ~fifo_full;
        // During NOP incoming tokens are simply dropped, so never stall the join.
        stop_input = alu_valid_q & fifo_full & (op_dec != OP_NOP);
        // CONST fires on its own; any token present in that cycle is consumed too.
        fire = (valid_input | (op_dec == OP_CONST)) & (op_dec != OP_NOP) &
               ~(alu_valid_q & fifo_full);

        alu_result = '0;
        case (op_dec)
            OP_ADD:   alu_result = input_data_1 + input_data_2;
            OP_SUB:   alu_result = input_data_1 - input_data_2;
            OP_MUL:   alu_result = input_data_1 * input_data_2;
            OP_CONST: alu_result = const_data;
            OP_LOAD:  alu_result = memory_read_data;
            OP_ROUTE: alu_result = input_data_1;
            default:  alu_result = '0;
        endcase

        alu_valid_d = alu_valid_q;
        alu_data_d  = alu_data_q;
        if (fifo_push) begin
            alu_valid_d = 1'b0;
        end
        if (fire && op_has_result(op_dec)) begin
            alu_valid_d = 1'b1;
            alu_data_d  = alu_result;
        end

        switch_context_d = fire;
        mem_we_d    = fire & (op_dec == OP_STORE);
        mem_waddr_d = mem_we_d ? ADDRESS_WIDTH'(input_data_1) : mem_waddr_q;
        mem_wdata_d = mem_we_d ? input_data_2 : mem_wdata_q;
    end

    assign memory_read_address  = valid_input ? ADDRESS_WIDTH'(input_data_1) : '0;
    assign memory_write_address = mem_waddr_q;
    assign memory_write_data    = mem_wdata_q;
    assign memory_write         = mem_we_q;
    assign switch_context       = switch_context_q;

    elastic_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ELASTIC_BUFFER_SIZE_BIT_LENGTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (alu_data_q),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
`ifdef ELASTIC_DEBUG_EN
        ,
        .occupancy (DEBUG_data_size)
`endif
    );

    assign fifo_valid = ~fifo_empty;

    // Eager fork: each output is offered the head until it takes it once;
    // masked-off outputs never hold up the pop.
    for (genvar gi = 0; gi < NEIGHBOR_PE_NUM; gi++) begin : g_fork
        assign valid_output[gi]   = fifo_valid & available_output[gi] & ~done_q[gi];
        assign out_ok[gi]         = done_q[gi] | ~available_output[gi] |
                                    (valid_output[gi] & ~stop_output[gi]);
        assign pe_output_data[gi] = fifo_head;
    end

    assign fifo_pop = fifo_valid & (&out_ok);

    always_comb begin
        done_d = fifo_pop ? '0 : (done_q | (valid_output & ~stop_output));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_valid_q      <= 1'b0;
            alu_data_q       <= '0;
            switch_context_q <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_waddr_q      <= '0;
            mem_wdata_q      <= '0;
            done_q           <= '0;
        end else begin
            alu_valid_q      <= alu_valid_d;
            alu_data_q       <= alu_data_d;
            switch_context_q <= switch_context_d;
            mem_we_q         <= mem_we_d;
            mem_waddr_q      <= mem_waddr_d;
            mem_wdata_q      <= mem_wdata_d;
            done_q           <= done_d;
        end
    end

endmodule

// File: tb/tb_elastic_alu_out_stage.sv
// tb_elastic_alu_out_stage
// Directed bench for elastic_alu_out_stage with hand-computed expectations.
// Optional ELASTIC_DEBUG_EN adds occupancy checks.
module tb_elastic_alu_out_stage;
    import elastic_alu_out_stage_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       input_data_1, input_data_2, const_data;
    logic              valid_input, stop_input;
    logic [3:0]        op;
    logic              switch_context;
    logic [31:0]       memory_read_address, memory_read_data;
    logic [31:0]       memory_write_address, memory_write_data;
    logic              memory_write;
    logic [3:0]        available_output, valid_output, stop_output;
    logic [3:0][31:0]  pe_output_data;
`ifdef ELASTIC_DEBUG_EN
    logic [2:0]        debug_size;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Tiny memory model: address 0x20 holds 0x55, everything else reads 0.
    assign memory_read_data = (memory_read_address == 32'h20) ? 32'h55 : 32'h0;

    elastic_alu_out_stage dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .input_data_1         (input_data_1),
        .input_data_2         (input_data_2),
        .valid_input          (valid_input),
        .stop_input           (stop_input),
        .op                   (op),
        .const_data           (const_data),
        .switch_context       (switch_context),
        .memory_read_address  (memory_read_address),
        .memory_read_data     (memory_read_data),
        .memory_write_address (memory_write_address),
        .memory_write_data    (memory_write_data),
        .memory_write         (memory_write),
        .available_output     (available_output),
        .pe_output_data       (pe_output_data),
        .valid_output         (valid_output),
        .stop_output          (stop_output)
`ifdef ELASTIC_DEBUG_EN
        ,
        .DEBUG_data_size      (debug_size)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        valid_input = 1'b0; op = OP_NOP; input_data_1 = '0; input_data_2 = '0;
        const_data = '0; available_output = '0; stop_output = '0;
        tick; tick;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL reset_valid_output: got %b want 0000", valid_output); end
        vectors++;
        if (stop_input !== 1'b0) begin miscompares++; $display("FAIL reset_stop_input: got %b want 0", stop_input); end
        vectors++;
        if (switch_context !== 1'b0 || memory_write !== 1'b0) begin miscompares++; $display("FAIL reset_ctx_mem: got switch=%b mw=%b want 0 0", switch_context, memory_write); end
        vectors++;
        if (memory_write_address !== 32'h0 || memory_write_data !== 32'h0) begin miscompares++; $display("FAIL reset_mem_regs: got addr=%h data=%h want 0 0", memory_write_address, memory_write_data); end
        reset_n = 1'b1;
        tick;
        $display("reset: outputs idle after reset");
    endtask

    // One firing of a single opcode with mask 0b0011, then check the token.
    task automatic test_alu_op(input string name, input logic [3:0] o, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] c, input logic v,
                               input logic has_result, input logic [31:0] expected);
        logic exp_sw;
        exp_sw = has_result || (o == OP_STORE);
        tick;
        op = o; input_data_1 = d1; input_data_2 = d2; const_data = c; valid_input = v;
        available_output = 4'b0011; stop_output = 4'b0000;
        #1;
        vectors++;
        if (stop_input !== 1'b0) begin miscompares++; $display("FAIL %s_stop_input: got %b want 0", name, stop_input); end
        tick;
        op = OP_NOP; valid_input = 1'b0;
        #1;
        vectors++;
        if (switch_context !== exp_sw) begin miscompares++; $display("FAIL %s_switch_context: got %b want %b", name, switch_context, exp_sw); end
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL %s_early_valid: got %b want 0000", name, valid_output); end
        tick;
        vectors++;
        if (valid_output !== (has_result ? 4'b0011 : 4'b0000)) begin miscompares++; $display("FAIL %s_valid_output: got %b want %b", name, valid_output, has_result ? 4'b0011 : 4'b0000); end
        if (has_result) begin
            vectors++;
            if (pe_output_data[0] !== expected || pe_output_data[1] !== expected) begin
                miscompares++; $display("FAIL %s_data: got %h/%h want %h", name, pe_output_data[0], pe_output_data[1], expected);
            end
        end
        vectors++;
        if (switch_context !== 1'b0) begin miscompares++; $display("FAIL %s_switch_pulse: got %b want 0", name, switch_context); end
        tick;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL %s_after_pop: got %b want 0000", name, valid_output); end
        $display("op %s: d1=%h d2=%h -> %h (result=%b)", name, d1, d2, expected, has_result);
    endtask

    task automatic test_fork_skew;
        tick;
        op = OP_ROUTE; input_data_1 = 32'h11; valid_input = 1'b1;
        available_output = 4'b0011; stop_output = 4'b0001;
        tick;
        op = OP_NOP; valid_input = 1'b0;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL skew_before: got %b want 0000", valid_output); end
        tick;
        vectors++;
        if (valid_output !== 4'b0011 || pe_output_data[1] !== 32'h11) begin miscompares++; $display("FAIL skew_offer: got %b/%h want 0011/11", valid_output, pe_output_data[1]); end
        tick;
        vectors++;
        if (valid_output !== 4'b0001 || pe_output_data[0] !== 32'h11) begin miscompares++; $display("FAIL skew_out1_done: got %b/%h want 0001/11", valid_output, pe_output_data[0]); end
        tick;
        vectors++;
        if (valid_output !== 4'b0001) begin miscompares++; $display("FAIL skew_hold: got %b want 0001", valid_output); end
        stop_output = 4'b0000;
        #1;
        tick;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL skew_release: got %b want 0000", valid_output); end
`ifdef ELASTIC_DEBUG_EN
        vectors++;
        if (debug_size !== 3'd0) begin miscompares++; $display("FAIL skew_occupancy: got %0d want 0", debug_size); end
`endif
        tick;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL skew_single_pop: got %b want 0000", valid_output); end
        $display("fork skew: token 0x11 delivered once to outputs 0 and 1");
    endtask

    task automatic test_back_pressure;
        int accepted;
        int recv;
        accepted = 0; recv = 0;
        tick;
        available_output = 4'b0001; stop_output = 4'b1111; op = OP_ROUTE; input_data_2 = '0;
        for (int c = 0; c < 10; c++) begin
            valid_input = 1'b1; input_data_1 = 32'h100 + 32'(accepted);
            #1;
            if (!stop_input) accepted++;
            tick;
        end
        input_data_1 = 32'h100 + 32'(accepted);
        #1;
        vectors++;
        if (accepted != 5) begin miscompares++; $display("FAIL bp_accepted: got %0d want 5", accepted); end
        vectors++;
        if (stop_input !== 1'b1) begin miscompares++; $display("FAIL bp_stop_input: got %b want 1", stop_input); end
`ifdef ELASTIC_DEBUG_EN
        vectors++;
        if (debug_size !== 3'd4) begin miscompares++; $display("FAIL bp_occupancy: got %0d want 4", debug_size); end
`endif
        stop_output = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            valid_input = (accepted < 6);
            input_data_1 = 32'h100 + 32'(accepted);
            #1;
            if (valid_input && !stop_input) accepted++;
            if (valid_output[0]) begin
                vectors++;
                if (pe_output_data[0] !== 32'h100 + 32'(recv)) begin
                    miscompares++; $display("FAIL bp_order_%0d: got %h want %h", recv, pe_output_data[0], 32'h100 + 32'(recv));
                end
                recv++;
            end
            tick;
        end
        valid_input = 1'b0; op = OP_NOP;
        vectors++;
        if (recv != 6 || accepted != 6) begin miscompares++; $display("FAIL bp_count: got recv=%0d acc=%0d want 6 6", recv, accepted); end
        $display("back-pressure: %0d accepted, %0d drained in order", accepted, recv);
    endtask

    task automatic test_store;
        tick;
        op = OP_STORE; input_data_1 = 32'h10; input_data_2 = 32'hAB; valid_input = 1'b1;
        available_output = 4'b1111; stop_output = 4'b0000;
        tick;
        op = OP_NOP; valid_input = 1'b0;
        vectors++;
        if (memory_write !== 1'b1 || memory_write_address !== 32'h10 || memory_write_data !== 32'hAB) begin
            miscompares++; $display("FAIL store_write: got we=%b a=%h d=%h want 1 10 ab", memory_write, memory_write_address, memory_write_data);
        end
        tick;
        vectors++;
        if (memory_write !== 1'b0 || valid_output !== 4'b0000) begin
            miscompares++; $display("FAIL store_after: got we=%b valid=%b want 0 0000", memory_write, valid_output);
        end
        tick;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL store_no_token: got %b want 0000", valid_output); end
        $display("store: mem[0x10] <= 0xab");
    endtask

    task automatic test_load;
        tick;
        op = OP_LOAD; input_data_1 = 32'h20; input_data_2 = '0; valid_input = 1'b1;
        available_output = 4'b0001; stop_output = 4'b0000;
        #1;
        vectors++;
        if (memory_read_address !== 32'h20) begin miscompares++; $display("FAIL load_addr: got %h want 20", memory_read_address); end
        tick;
        op = OP_NOP; valid_input = 1'b0;
        #1;
        vectors++;
        if (memory_read_address !== 32'h0) begin miscompares++; $display("FAIL load_addr_idle: got %h want 0", memory_read_address); end
        tick;
        vectors++;
        if (valid_output !== 4'b0001 || pe_output_data[0] !== 32'h55) begin
            miscompares++; $display("FAIL load_data: got %b/%h want 0001/55", valid_output, pe_output_data[0]);
        end
        tick;
        $display("load: mem[0x20] -> 0x55");
    endtask

    task automatic test_reset_mid;
        tick;
        available_output = 4'b0001; stop_output = 4'b1111; op = OP_ROUTE; valid_input = 1'b1;
        input_data_1 = 32'h200;
        tick; input_data_1 = 32'h201;
        tick; input_data_1 = 32'h202;
        tick; valid_input = 1'b0; op = OP_NOP;
        tick;
        vectors++;
        if (valid_output !== 4'b0001) begin miscompares++; $display("FAIL rst_mid_before: got %b want 0001", valid_output); end
`ifdef ELASTIC_DEBUG_EN
        vectors++;
        if (debug_size !== 3'd3) begin miscompares++; $display("FAIL rst_mid_occupancy: got %0d want 3", debug_size); end
`endif
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (valid_output !== 4'b0000) begin miscompares++; $display("FAIL rst_mid_async: got %b want 0000", valid_output); end
        tick; tick;
        reset_n = 1'b1; stop_output = 4'b0000;
        tick; tick;
        vectors++;
        if (valid_output !== 4'b0000 || stop_input !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_after: got valid=%b stop=%b want 0000 0", valid_output, stop_input);
        end
`ifdef ELASTIC_DEBUG_EN
        vectors++;
        if (debug_size !== 3'd0) begin miscompares++; $display("FAIL rst_mid_empty: got %0d want 0", debug_size); end
`endif
        $display("reset mid-operation: 3 buffered tokens discarded");
    endtask

    initial begin
        test_reset;
        test_alu_op("ADD",   OP_ADD,   32'd3,         32'd4,  32'h0,  1'b1, 1'b1, 32'd7);
        test_alu_op("SUB",   OP_SUB,   32'd3,         32'd5,  32'h0,  1'b1, 1'b1, 32'hFFFF_FFFE);
        test_alu_op("MUL",   OP_MUL,   32'h1234_5678, 32'h10, 32'h0,  1'b1, 1'b1, 32'h2345_6780);
        test_alu_op("CONST", OP_CONST, 32'h0,         32'h0,  32'h77, 1'b0, 1'b1, 32'h77);
        test_alu_op("ROUTE", OP_ROUTE, 32'hCAFE,      32'h1,  32'h0,  1'b1, 1'b1, 32'hCAFE);
        test_alu_op("NOP",   OP_NOP,   32'h5,         32'h6,  32'h0,  1'b1, 1'b0, 32'h0);
        test_alu_op("OP9",   4'd9,     32'h5,         32'h6,  32'h0,  1'b1, 1'b0, 32'h0);
        test_fork_skew;
        test_back_pressure;
        test_store;
        test_load;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
